// File: rtl/tdm_mux.sv
// Round-robin TDM serialiser: snapshots d at frame start, emits one channel per DWELL-cycle slot with its select code.
// Latency: first slot appears one cycle after en is sampled high. No backpressure; en is sampled only at idle and at frame boundaries.
module tdm_mux #(
    parameter int N_CH   = 8,
    parameter int SEL_W  = 3,
    parameter int DWIDTH = 1,
    parameter int DWELL  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [N_CH*DWIDTH-1:0]   d,
    output logic [DWIDTH-1:0]        y,
    output logic [SEL_W-1:0]         s,
    output logic                     valid,
    output logic                     frame_start
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam int               CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] S_LAST   = SEL_W'(N_CH - 1);

    logic [0:0]                    state;
    logic [N_CH-1:0][DWIDTH-1:0]   snap;
    logic [CNT_W-1:0]              dwell_cnt;
    logic [SEL_W-1:0]              s_nxt;

    assign s_nxt = s + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            snap        <= '0;
            dwell_cnt   <= '0;
            y           <= '0;
            s           <= '0;
            valid       <= 1'b0;
            frame_start <= 1'b0;
        end else if (state == IDLE) begin
            dwell_cnt <= '0;
            s         <= '0;
            if (en) begin
                snap        <= d;
                y           <= d[DWIDTH-1:0];
                valid       <= 1'b1;
                frame_start <= 1'b1;
                state       <= RUN;
            end else begin
                y           <= '0;
                valid       <= 1'b0;
                frame_start <= 1'b0;
            end
        end else begin
            frame_start <= 1'b0;
            if (dwell_cnt != CNT_LAST) begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end else begin
                dwell_cnt <= '0;
                if (s != S_LAST) begin
                    s <= s_nxt;
                    y <= snap[s_nxt];
                end else if (en) begin
                    // back-to-back frame: fresh snapshot, no gap cycle
                    snap        <= d;
                    s           <= '0;
                    y           <= d[DWIDTH-1:0];
                    frame_start <= 1'b1;
                end else begin
                    state <= IDLE;
                    valid <= 1'b0;
                    y     <= '0;
                    s     <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_mux.sv
// Bench for tdm_mux: vector table with scoreboard queue on an 8x1 DWELL=1 instance, hand sequences for reset and a 4x2 DWELL=3 instance.
module tb_tdm_mux;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // instance A: N_CH=8, DWIDTH=1, DWELL=1
    logic       en_a = 1'b0;
    logic [7:0] d_a  = '0;
    logic       y_a;
    logic [2:0] s_a;
    logic       valid_a, fs_a;

    // instance B: N_CH=4, DWIDTH=2, DWELL=3
    logic       en_b = 1'b0;
    logic [7:0] d_b  = '0;
    logic [1:0] y_b;
    logic [1:0] s_b;
    logic       valid_b, fs_b;

    tdm_mux #(.N_CH(8), .SEL_W(3), .DWIDTH(1), .DWELL(1)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .d(d_a),
        .y(y_a), .s(s_a), .valid(valid_a), .frame_start(fs_a)
    );

    tdm_mux #(.N_CH(4), .SEL_W(2), .DWIDTH(2), .DWELL(3)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .d(d_b),
        .y(y_b), .s(s_b), .valid(valid_b), .frame_start(fs_b)
    );

    typedef struct {
        logic       en;
        logic [7:0] d;
        logic [1:0] y;
        logic [2:0] s;
        logic       v;
        logic       fs;
    } vec_t;

    typedef struct {
        logic [1:0] y;
        logic [2:0] s;
        logic       v;
        logic       fs;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic [7:0] d, input logic [1:0] y,
                       input logic [2:0] s, input logic v, input logic fs);
        vec_t t;
        t.en = en; t.d = d; t.y = y; t.s = s; t.v = v; t.fs = fs;
        vecs.push_back(t);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] pa;
        logic [7:0] d1;
        logic [7:0] d2;
        exp_t       e;
        int         k;
        pa = 8'hA6;
        d1 = 8'b11_10_01_00;
        d2 = 8'b00_01_10_11;

        // ---- build the vector table for instance A ----
        add(1'b0, pa, 2'd0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            add(1'b1, (i < 4) ? pa : 8'hFF, {1'b0, pa[i]}, 3'(i), 1'b1, i == 0);
        for (int i = 0; i < 8; i++)
            add(1'b1, 8'hFF, 2'd1, 3'(i), 1'b1, i == 0);
        for (int i = 0; i < 8; i++)
            add(i <= 2, pa, {1'b0, pa[i]}, 3'(i), 1'b1, i == 0);
        for (int i = 0; i < 5; i++)
            add(1'b0, 8'hFF, 2'd0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            add(1'b1, 8'hFF, 2'd1, 3'(i), 1'b1, i == 0);

        // ---- reset state ----
        tick;
        tick;
        check("rst_y_a", 0, 32'(y_a), 0);
        check("rst_s_a", 0, 32'(s_a), 0);
        check("rst_v_a", 0, 32'(valid_a), 0);
        check("rst_fs_a", 0, 32'(fs_a), 0);
        check("rst_v_b", 0, 32'(valid_b), 0);
        check("rst_fs_b", 0, 32'(fs_b), 0);
        rst = 1'b0;

        // ---- table-driven run on A through the scoreboard ----
        for (int i = 0; i < vecs.size(); i++) begin
            en_a = vecs[i].en;
            d_a  = vecs[i].d;
            e.y = vecs[i].y; e.s = vecs[i].s; e.v = vecs[i].v; e.fs = vecs[i].fs;
            sb.push_back(e);
            tick;
            e = sb.pop_front();
            check("a_y",  i, 32'(y_a),     32'(e.y));
            check("a_s",  i, 32'(s_a),     32'(e.s));
            check("a_v",  i, 32'(valid_a), 32'(e.v));
            check("a_fs", i, 32'(fs_a),    32'(e.fs));
        end

        // ---- asynchronous reset mid-frame (s=5), checked before the next edge ----
        rst = 1'b1;
        #2;
        check("arst_y", 0, 32'(y_a), 0);
        check("arst_s", 0, 32'(s_a), 0);
        check("arst_v", 0, 32'(valid_a), 0);
        check("arst_fs", 0, 32'(fs_a), 0);
        tick;
        rst  = 1'b0;
        en_a = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick;
            check("idle_v", i, 32'(valid_a), 0);
            check("idle_s", i, 32'(s_a), 0);
            check("idle_y", i, 32'(y_a), 0);
        end

        // ---- instance B: DWELL=3, two back-to-back frames, d changed mid-frame ----
        d_b = d1;
        for (int c = 0; c <= 24; c++) begin
            en_b = (c <= 12);
            if (c == 5) d_b = d2;
            k = c % 12;
            if (c < 24) begin
                e.s  = 3'(k / 3);
                e.y  = (c < 12) ? 2'(k / 3) : 2'(3 - k / 3);
                e.v  = 1'b1;
                e.fs = (k == 0);
            end else begin
                e.s = '0; e.y = '0; e.v = 1'b0; e.fs = 1'b0;
            end
            sb.push_back(e);
            tick;
            e = sb.pop_front();
            check("b_y",  c, 32'(y_b),     32'(e.y));
            check("b_s",  c, 32'(s_b),     32'(e.s));
            check("b_v",  c, 32'(valid_b), 32'(e.v));
            check("b_fs", c, 32'(fs_b),    32'(e.fs));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_mux.md
Name: tdm_mux

Overview:
Time-division multiplexer that serialises N_CH parallel channels onto one shared line and drives the channel-select code alongside the data. It is the transmit end of the demux-based link: its y/s outputs connect directly to the demux a/s inputs at the far end. A snapshot of all channels is taken at each frame start, so every frame is coherent. Channels are scanned round-robin, with each slot held for DWELL clock cycles.

Parameters:
N_CH, 8, number of channels (power of two, >= 2)
SEL_W, 3, select width, equal to log2(N_CH)
DWIDTH, 1, bits per channel
DWELL, 1, clock cycles per slot (>= 1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  run request; sampled at idle and at frame boundaries only
d  input  N_CH*DWIDTH  channel data; channel k occupies d[k*DWIDTH +: DWIDTH]
y  output  DWIDTH  serialised data for the current slot (registered)
s  output  SEL_W  channel index of the current slot (registered)
valid  output  1  high while y/s carry a live slot
frame_start  output  1  one-cycle pulse on the first cycle of slot 0

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: y=0, s=0, valid=0, frame_start=0. Internal state: state=IDLE, snap=0, dwell_cnt=0. Reset takes effect immediately, including mid-frame; the partial frame is discarded.
- States are IDLE and RUN. All outputs are registered.
- IDLE, en=0: hold y=0, s=0, valid=0, frame_start=0.
- IDLE, en=1 at a rising edge, on that edge:
  - snap<=d, y<=d[ch0], s<=0, valid<=1, frame_start<=1, dwell_cnt<=0, state<=RUN.
  - Latency from en sampled high to the first valid slot is one cycle.
- RUN, dwell_cnt < DWELL-1: dwell_cnt++. y and s hold, frame_start<=0. The en input is ignored.
- RUN, dwell_cnt == DWELL-1 and s < N_CH-1 (slot end):
  - dwell_cnt<=0, s<=s+1, y<=snap[s+1], frame_start<=0.
- RUN, dwell_cnt == DWELL-1 and s == N_CH-1 (frame boundary):
  - en=1: snap<=d, s<=0, y<=d[ch0], frame_start<=1, and RUN continues. Frames run back-to-back with no gap cycle.
  - en=0: state<=IDLE, valid<=0, y<=0, s<=0, frame_start<=0.
- en deasserted mid-frame: the frame always completes. Stopping happens only at a frame boundary.
- Changes on d during a frame do not affect it. Only the snapshot taken at frame start is transmitted.
- frame_start is high for exactly one cycle per frame, even when DWELL > 1.
- Wrap-around: s goes N_CH-1 -> 0 with no skipped or repeated index.
- Frame length is exactly N_CH*DWELL cycles. valid stays continuously high across consecutive frames.

Test Plan:
- Reset then idle: assert rst mid-run with s=5 -> y=0, s=0, valid=0, frame_start=0 immediately (before the next clk edge); with en=0 the outputs stay at 0.
- Basic frame: N_CH=8, DWELL=1, d=8'b1010_0110, en=1 held -> starting one cycle after en, y sequence 0,1,1,0,0,1,0,1 with s=0..7; frame_start high only while s=0.
- Snapshot coherence: change d to 8'hFF while s=3 in the frame started with 8'b1010_0110 -> remaining slots still give 0,1,0,1; the next frame gives all 1s.
- Back-to-back and stop: en held for 2 frames, then dropped while s=2 of frame 3 -> 24 consecutive valid cycles, s wraps 7->0 twice, frame 3 completes, then valid=0, y=0, s=0.
- Dwell: DWELL=3, N_CH=4, DWIDTH=2, d=8'b11_10_01_00 -> y is 0,0,0,1,1,1,2,2,2,3,3,3 with s stepping every 3 cycles; frame_start is a single 1-cycle pulse per 12-cycle frame.
- Restart after idle: en=0 for 5 cycles after a frame ends, then en=1 -> first slot y=d[ch0], s=0, frame_start=1 exactly one cycle later.
